// File: rtl/mcu_debug_controller.sv
// Run-control and register-read sequencer for the 8-bit MCU core.
// Optional breakpoint compare is enabled with `define MCU_DBG_BREAKPOINT_EN.
module mcu_debug_controller #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int PC_WIDTH      = 8,
  parameter bit HALT_ON_RESET = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  instr_done,
  input  logic [DATA_WIDTH-1:0] reg_out,
  input  logic [PC_WIDTH-1:0]   currentPC,
  output logic                  core_en,
  output logic                  dbg_addr_sel,
  output logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic                  halted
`ifdef MCU_DBG_BREAKPOINT_EN
  ,
  input  logic [PC_WIDTH-1:0]   bp_addr,
  input  logic                  bp_valid
`endif
);

  typedef enum logic [2:0] {
    S_HALT, S_RUN, S_STEP, S_RD_ADDR, S_RD_DATA
  } state_t;

  localparam logic [1:0] OP_HALT = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  localparam state_t RST_STATE = HALT_ON_RESET ? S_HALT : S_RUN;

  state_t state, next_state;
  logic   accept, ld_addr, bp_hit;

`ifdef MCU_DBG_BREAKPOINT_EN
  // Armed only after the first instruction retires in RUN, so resuming
  // at the breakpoint address makes progress.
  logic bp_armed;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      bp_armed <= 1'b0;
    else if (state != S_RUN)
      bp_armed <= 1'b0;
    else if (instr_done)
      bp_armed <= 1'b1;
  end

  assign bp_hit = (state == S_RUN) && bp_armed && bp_valid &&
                  (currentPC == bp_addr) && instr_done;
`else
  logic unused_pc;
  assign unused_pc = ^currentPC;
  assign bp_hit    = 1'b0;
`endif

  assign cmd_ready = (state == S_HALT) || (state == S_RUN);
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    next_state = state;
    ld_addr    = 1'b0;
    case (state)
      S_HALT: begin
        if (accept) begin
          case (cmd_op)
            OP_RUN:  next_state = S_RUN;
            OP_STEP: next_state = S_STEP;
            OP_READ: begin
              next_state = S_RD_ADDR;
              ld_addr    = 1'b1;
            end
            default: next_state = S_HALT;
          endcase
        end
      end
      // Non-HALT commands in RUN are accepted and dropped.
      S_RUN:     if ((accept && cmd_op == OP_HALT) || bp_hit) next_state = S_HALT;
      S_STEP:    if (instr_done) next_state = S_HALT;
      S_RD_ADDR: next_state = S_RD_DATA;
      S_RD_DATA: next_state = S_HALT;
      default:   next_state = S_HALT;
    endcase
  end

  // Outputs are registered from next_state so they change on the accepting edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= RST_STATE;
      core_en      <= !HALT_ON_RESET;
      halted       <= HALT_ON_RESET;
      dbg_addr_sel <= 1'b0;
      dbg_addr     <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
    end else begin
      state        <= next_state;
      core_en      <= (next_state == S_RUN) || (next_state == S_STEP);
      halted       <= (next_state == S_HALT);
      dbg_addr_sel <= (next_state == S_RD_ADDR) || (next_state == S_RD_DATA);
      rsp_valid    <= (state == S_RD_DATA);
      if (state == S_RD_DATA) rsp_data <= reg_out;
      if (ld_addr)            dbg_addr <= cmd_addr;
    end
  end

endmodule

// File: tb/tb_mcu_debug_controller.sv
// Bench for mcu_debug_controller: vector table, corner sequences, random vs model.
module tb_mcu_debug_controller;
  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [3:0] cmd_addr = 4'd0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       instr_done = 1'b0;
  logic [7:0] reg_out;
  logic [7:0] currentPC;
  logic       core_en, dbg_addr_sel, halted;
  logic [3:0] dbg_addr;
`ifdef MCU_DBG_BREAKPOINT_EN
  logic [7:0] bp_addr = 8'd0;
  logic       bp_valid = 1'b0;
`endif

  int passed = 0;
  int total  = 0;

  mcu_debug_controller dut (
    .Clk(Clk), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .instr_done(instr_done), .reg_out(reg_out), .currentPC(currentPC),
    .core_en(core_en), .dbg_addr_sel(dbg_addr_sel), .dbg_addr(dbg_addr), .halted(halted)
`ifdef MCU_DBG_BREAKPOINT_EN
    , .bp_addr(bp_addr), .bp_valid(bp_valid)
`endif
  );

  always #5 Clk = ~Clk;

  // Environment: register file and a PC that advances per retired instruction.
  logic [7:0] regs [16];
  assign reg_out = regs[dbg_addr_sel ? dbg_addr : 4'd0];

  always @(posedge Clk or posedge Reset) begin
    if (Reset) currentPC <= 8'd0;
    else if (core_en && instr_done) currentPC <= currentPC + 8'd1;
  end

  // Reference model: run/step flags plus a read countdown.
  bit       m_run, m_step;
  int       m_rd;
  bit       m_rv;
  bit [7:0] m_data;
  bit [3:0] m_addr;

  function automatic void model_reset();
    m_run = 0; m_step = 0; m_rd = 0; m_rv = 0; m_data = 0; m_addr = 0;
  endfunction

  function automatic void model_edge(bit v, bit [1:0] op, bit [3:0] a, bit id);
    m_rv = 0;
    if (m_rd == 1) begin
      m_rv = 1; m_data = regs[m_addr]; m_rd = 0;
    end else if (m_rd == 2) m_rd = 1;
    else if (m_step) begin
      if (id) m_step = 0;
    end else if (v) begin
      if (m_run) begin
        if (op == 2'd0) m_run = 0;
      end else begin
        if (op == 2'd1) m_run = 1;
        else if (op == 2'd2) m_step = 1;
        else if (op == 2'd3) begin m_addr = a; m_rd = 2; end
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " core_en"},  32'(core_en),      32'(m_run || m_step));
    chk({tag, " halted"},   32'(halted),       32'(!m_run && !m_step && m_rd == 0));
    chk({tag, " cmd_ready"},32'(cmd_ready),    32'(!m_step && m_rd == 0));
    chk({tag, " sel"},      32'(dbg_addr_sel), 32'(m_rd > 0));
    chk({tag, " rsp_valid"},32'(rsp_valid),    32'(m_rv));
    chk({tag, " rsp_data"}, 32'(rsp_data),     32'(m_data));
    chk({tag, " dbg_addr"}, 32'(dbg_addr),     32'(m_addr));
  endtask

  task automatic cyc(input bit v, input bit [1:0] op, input bit [3:0] a, input bit id);
    cmd_valid = v; cmd_op = op; cmd_addr = a; instr_done = id;
    @(posedge Clk);
    model_edge(v, op, a, id);
    #1;
  endtask

  task automatic idle(input bit id);
    cyc(1'b0, 2'd0, 4'd0, id);
  endtask

  // Reset asserted mid-cycle: outputs must clear without waiting for a clock.
  task automatic do_reset(input string tag);
    Reset = 1'b1;
    #2;
    chk({tag, " rst halted"},  32'(halted),       32'd1);
    chk({tag, " rst core_en"}, 32'(core_en),      32'd0);
    chk({tag, " rst sel"},     32'(dbg_addr_sel), 32'd0);
    chk({tag, " rst rsp_vld"}, 32'(rsp_valid),    32'd0);
    model_reset();
    @(posedge Clk); #1;
    Reset = 1'b0;
  endtask

  typedef struct {
    bit v; bit [1:0] op; bit [3:0] a; bit id;
    bit e_en; bit e_halt; bit e_rdy; bit e_sel; bit e_rv; bit [7:0] e_data;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int en_cnt, pc0, n;
    bit v, id; bit [1:0] op; bit [3:0] a;
    for (int i = 0; i < 16; i++) regs[i] = 8'(i * 37 + 11);
    regs[5] = 8'hA7;
    model_reset();

    //            v  op a  id  en hl rdy sel rv data
    tbl[0]  = '{0, 0, 0, 0,  0, 1, 1,  0, 0, 8'h00};
    tbl[1]  = '{1, 1, 0, 0,  1, 0, 1,  0, 0, 8'h00};
    tbl[2]  = '{1, 2, 0, 0,  1, 0, 1,  0, 0, 8'h00};
    tbl[3]  = '{1, 0, 0, 0,  0, 1, 1,  0, 0, 8'h00};
    tbl[4]  = '{1, 2, 0, 1,  1, 0, 0,  0, 0, 8'h00};
    tbl[5]  = '{0, 0, 0, 0,  1, 0, 0,  0, 0, 8'h00};
    tbl[6]  = '{0, 0, 0, 1,  0, 1, 1,  0, 0, 8'h00};
    tbl[7]  = '{1, 3, 5, 0,  0, 0, 0,  1, 0, 8'h00};
    tbl[8]  = '{1, 3, 3, 0,  0, 0, 0,  1, 0, 8'h00};
    tbl[9]  = '{0, 0, 0, 0,  0, 1, 1,  0, 1, 8'hA7};
    tbl[10] = '{1, 0, 0, 0,  0, 1, 1,  0, 0, 8'hA7};

    repeat (2) @(posedge Clk);
    #1;
    chk("reset halted",    32'(halted),    32'd1);
    chk("reset core_en",   32'(core_en),   32'd0);
    chk("reset rsp_data",  32'(rsp_data),  32'h00);
    chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
    Reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].v, tbl[i].op, tbl[i].a, tbl[i].id);
      chk($sformatf("vec%0d core_en", i),   32'(core_en),      32'(tbl[i].e_en));
      chk($sformatf("vec%0d halted", i),    32'(halted),       32'(tbl[i].e_halt));
      chk($sformatf("vec%0d cmd_ready", i), 32'(cmd_ready),    32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d sel", i),       32'(dbg_addr_sel), 32'(tbl[i].e_sel));
      chk($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid),    32'(tbl[i].e_rv));
      chk($sformatf("vec%0d rsp_data", i),  32'(rsp_data),     32'(tbl[i].e_data));
      if (tbl[i].e_sel) chk($sformatf("vec%0d dbg_addr", i), 32'(dbg_addr), 32'd5);
    end

    // RUN for 10 cycles with an instruction retiring every cycle, then HALT.
    pc0 = int'(currentPC);
    en_cnt = 0;
    cyc(1'b1, 2'd1, 4'd0, 1'b1);
    if (core_en) en_cnt++;
    for (int i = 0; i < 9; i++) begin idle(1'b1); if (core_en) en_cnt++; end
    cyc(1'b1, 2'd0, 4'd0, 1'b1);
    chk("run10 en cycles", 32'(en_cnt), 32'd10);
    chk("run10 halted", 32'(halted), 32'd1);
    chk("run10 pc advance", 32'((int'(currentPC) - pc0) & 255), 32'd10);
    pc0 = int'(currentPC);
    for (int i = 0; i < 5; i++) idle(1'b1);
    chk("pc frozen", 32'(currentPC), 32'(pc0));

    // STEP with instr_done every 3rd cycle.
    pc0 = int'(currentPC);
    en_cnt = 0;
    cyc(1'b1, 2'd2, 4'd0, 1'b0);
    if (core_en) en_cnt++;
    idle(1'b0); if (core_en) en_cnt++;
    idle(1'b0); if (core_en) en_cnt++;
    idle(1'b1); if (core_en) en_cnt++;
    chk("step en cycles", 32'(en_cnt), 32'd3);
    chk("step pc +1", 32'((int'(currentPC) - pc0) & 255), 32'd1);
    chk("step halted", 32'(halted), 32'd1);

    // Reset during STEP and during RD_ADDR abandons the operation.
    cyc(1'b1, 2'd2, 4'd0, 1'b0);
    chk("step active", 32'(core_en), 32'd1);
    do_reset("mid-step");
    cyc(1'b1, 2'd3, 4'd7, 1'b0);
    chk("read active", 32'(dbg_addr_sel), 32'd1);
    do_reset("mid-read");
    n = 0;
    for (int i = 0; i < 4; i++) begin idle(1'b0); if (rsp_valid) n++; end
    chk("no rsp after reset", 32'(n), 32'd0);
    chk_model("post-reset");

`ifdef MCU_DBG_BREAKPOINT_EN
    begin
      bit [7:0] pc_before;
      bit hit;
      do_reset("bp");
      bp_addr = 8'h04; bp_valid = 1'b1;
      cyc(1'b1, 2'd1, 4'd0, 1'b1);
      hit = 0;
      for (int i = 0; i < 50 && !hit; i++) begin
        pc_before = currentPC;
        cmd_valid = 0; instr_done = 1;
        @(posedge Clk); #1;
        if (halted) begin hit = 1; chk("bp halt pc", 32'(pc_before), 32'h04); end
      end
      chk("bp hit seen", 32'(hit), 32'd1);
      cmd_valid = 1; cmd_op = 2'd1; instr_done = 1;
      @(posedge Clk); #1;
      cmd_valid = 0;
      repeat (10) begin @(posedge Clk); #1; end
      chk("bp second run", 32'(halted), 32'd0);
      bp_valid = 1'b0;
      do_reset("bp end");
    end
`endif

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 99) < 50);
      op = 2'($urandom_range(0, 3));
      a  = 4'($urandom);
      id = ($urandom_range(0, 99) < 30);
      cyc(v, op, a, id);
      if (i % 8 == 0 || rsp_valid) chk_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
